// File: rtl/dp_ram_param.sv
// dp_ram_param: parametrised true dual-port synchronous RAM on one clock.
// Two independent read/write ports with selectable same-port read-during-write
// behaviour, an optional output register stage, write-write collision
// arbitration (port A wins) and a post-reset clear of the whole array.
//
// Handshake: an access is accepted on a rising edge when en_x=1 and busy=0.
// Each accepted access produces exactly one valid_x pulse: in the cycle after
// the accepting edge (OUT_REG=0) or one cycle later (OUT_REG=1). dout_x holds
// its last value whenever valid_x is low. No backpressure exists.
module dp_ram_param #(
   parameter int DATA_W       = 8,
   parameter int ADDR_W       = 6,
   parameter int DEPTH        = (1 << ADDR_W),
   parameter int RD_MODE      = 0,
   parameter int OUT_REG      = 0,
   parameter int CLEAR_ON_RST = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_a,
   input  logic              wr_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] din_a,
   output logic [DATA_W-1:0] dout_a,
   output logic              valid_a,
   input  logic              en_b,
   input  logic              wr_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] din_b,
   output logic [DATA_W-1:0] dout_b,
   output logic              valid_b,
   output logic              busy,
   output logic              collision
);

   // Clear FSM states; state is the observable debug view of the clear engine.
   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } clr_state_t;

   // clr_cnt is one bit wider than the address so DEPTH = 2**ADDR_W
   // still has a representable last index and terminal comparison.
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST_L  = (ADDR_W+1)'(DEPTH - 1);

   clr_state_t        state;
   logic [ADDR_W:0]   clr_cnt;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              idle;
   logic              acc_a;
   logic              acc_b;
   logic              in_rng_a;
   logic              in_rng_b;
   logic              same_addr;
   logic              wr_a_ok;
   logic              wr_b_ok;
   logic              coll_nxt;
   logic [DATA_W-1:0] rd_a_nxt;
   logic [DATA_W-1:0] rd_b_nxt;

   // First read stage: the read result of the accepting edge.
   logic [DATA_W-1:0] rd_a_q;
   logic [DATA_W-1:0] rd_b_q;
   logic              rv_a_q;
   logic              rv_b_q;

   assign idle      = (state == S_IDLE);
   assign acc_a     = idle && en_a;
   assign acc_b     = idle && en_b;
   assign in_rng_a  = ({1'b0, addr_a} < DEPTH_L);
   assign in_rng_b  = ({1'b0, addr_b} < DEPTH_L);
   assign same_addr = (addr_a == addr_b);

   // Port A always wins a same-address write; B's write is dropped.
   assign wr_a_ok   = acc_a && wr_a && in_rng_a;
   assign wr_b_ok   = acc_b && wr_b && in_rng_b && !(acc_a && wr_a && same_addr);
   assign coll_nxt  = acc_a && wr_a && acc_b && wr_b && same_addr;

   // Per-port read value: out-of-range reads give zero, otherwise the
   // same-port write data (write-first) or the stored old word.
   always_comb begin
      rd_a_nxt = '0;
      rd_b_nxt = '0;
      if (in_rng_a) begin
         if ((RD_MODE != 0) && wr_a) rd_a_nxt = din_a;
         else                        rd_a_nxt = mem[addr_a];
      end
      if (in_rng_b) begin
         if ((RD_MODE != 0) && wr_b) rd_b_nxt = din_b;
         else                        rd_b_nxt = mem[addr_b];
      end
   end

   // Clear FSM: walks clr_cnt from 0 to DEPTH-1 after reset, holding busy high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_IDLE;
         clr_cnt <= '0;
         busy    <= (CLEAR_ON_RST != 0);
      end else begin
         case (state)
            S_CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == LAST_L) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Array write: the clear engine owns the array while clearing, otherwise
   // the arbitrated port writes land. No reset of the array contents here.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == S_CLEAR) begin
            mem[clr_cnt[ADDR_W-1:0]] <= '0;
         end else begin
            if (wr_a_ok) mem[addr_a] <= din_a;
            if (wr_b_ok) mem[addr_b] <= din_b;
         end
      end
   end

   // First read stage and collision flag, both registered at the accepting edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_a_q    <= '0;
         rd_b_q    <= '0;
         rv_a_q    <= 1'b0;
         rv_b_q    <= 1'b0;
         collision <= 1'b0;
      end else begin
         rv_a_q    <= acc_a;
         rv_b_q    <= acc_b;
         collision <= coll_nxt;
         if (acc_a) rd_a_q <= rd_a_nxt;
         if (acc_b) rd_b_q <= rd_b_nxt;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_W-1:0] out_a_q;
         logic [DATA_W-1:0] out_b_q;
         logic              ov_a_q;
         logic              ov_b_q;

         // Extra output stage: forwards the first stage one cycle later and
         // keeps the last delivered word across idle cycles.
         always_ff @(posedge clk) begin
            if (rst) begin
               out_a_q <= '0;
               out_b_q <= '0;
               ov_a_q  <= 1'b0;
               ov_b_q  <= 1'b0;
            end else begin
               ov_a_q <= rv_a_q;
               ov_b_q <= rv_b_q;
               if (rv_a_q) out_a_q <= rd_a_q;
               if (rv_b_q) out_b_q <= rd_b_q;
            end
         end

         assign dout_a  = out_a_q;
         assign dout_b  = out_b_q;
         assign valid_a = ov_a_q;
         assign valid_b = ov_b_q;
      end else begin : g_no_out_reg
         assign dout_a  = rd_a_q;
         assign dout_b  = rd_b_q;
         assign valid_a = rv_a_q;
         assign valid_b = rv_b_q;
      end
   endgenerate

endmodule

// File: tb/tb_dp_ram_param.sv
// Bench for dp_ram_param. Two instances share one stimulus stream:
// u_d0 uses the default parameters (read-first, 1-cycle latency, 64 words),
// u_d1 is write-first with the output register and only 48 of 64 words
// populated, so out-of-range addresses are exercised.
module tb_dp_ram_param;

   localparam int DW = 8;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          en_a, wr_a, en_b, wr_b;
   logic [AW-1:0] addr_a, addr_b;
   logic [DW-1:0] din_a, din_b;

   logic [DW-1:0] dout_a0, dout_b0, dout_a1, dout_b1;
   logic          valid_a0, valid_b0, valid_a1, valid_b1;
   logic          busy0, busy1, coll0, coll1;

   always #5 clk = ~clk;

   dp_ram_param #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(64),
      .RD_MODE(0), .OUT_REG(0), .CLEAR_ON_RST(1)
   ) u_d0 (
      .clk(clk), .rst(rst),
      .en_a(en_a), .wr_a(wr_a), .addr_a(addr_a), .din_a(din_a),
      .dout_a(dout_a0), .valid_a(valid_a0),
      .en_b(en_b), .wr_b(wr_b), .addr_b(addr_b), .din_b(din_b),
      .dout_b(dout_b0), .valid_b(valid_b0),
      .busy(busy0), .collision(coll0)
   );

   dp_ram_param #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(48),
      .RD_MODE(1), .OUT_REG(1), .CLEAR_ON_RST(1)
   ) u_d1 (
      .clk(clk), .rst(rst),
      .en_a(en_a), .wr_a(wr_a), .addr_a(addr_a), .din_a(din_a),
      .dout_a(dout_a1), .valid_a(valid_a1),
      .en_b(en_b), .wr_b(wr_b), .addr_b(addr_b), .din_b(din_b),
      .dout_b(dout_b1), .valid_b(valid_b1),
      .busy(busy1), .collision(coll1)
   );

   // ---------------- behavioural reference model ----------------
   int            depth_m [2] = '{64, 48};
   int            rdm_m   [2] = '{0, 1};
   int            orm_m   [2] = '{0, 1};
   logic [DW-1:0] mm      [2][64];
   int            busy_left [2];
   logic [DW-1:0] e_da [2], e_db [2], p_da [2], p_db [2];
   logic          e_va [2], e_vb [2], p_va [2], p_vb [2];
   logic          e_busy [2], e_coll [2];

   int n_cmp = 0;
   int n_bad = 0;

   function automatic logic [DW-1:0] port_read(int k, logic wr, logic [AW-1:0] a,
                                               logic [DW-1:0] d);
      if (int'(a) >= depth_m[k]) return '0;
      if (wr && (rdm_m[k] == 1)) return d;
      return mm[k][a];
   endfunction

   // Advance the model over the next rising edge, given the current inputs.
   task automatic model_step();
      logic [DW-1:0] ra, rb;
      logic          va, vb;
      for (int k = 0; k < 2; k++) begin
         ra = '0; rb = '0; va = 1'b0; vb = 1'b0;
         if (rst) begin
            busy_left[k] = depth_m[k];
            e_da[k] = '0; e_db[k] = '0; e_va[k] = 1'b0; e_vb[k] = 1'b0;
            p_da[k] = '0; p_db[k] = '0; p_va[k] = 1'b0; p_vb[k] = 1'b0;
            e_coll[k] = 1'b0;
            e_busy[k] = 1'b1;
         end else begin
            e_coll[k] = 1'b0;
            if (busy_left[k] > 0) begin
               busy_left[k]--;
               if (busy_left[k] == 0)
                  for (int i = 0; i < 64; i++) mm[k][i] = '0;
            end else begin
               if (en_a) begin va = 1'b1; ra = port_read(k, wr_a, addr_a, din_a); end
               if (en_b) begin vb = 1'b1; rb = port_read(k, wr_b, addr_b, din_b); end
               if (en_a && wr_a && en_b && wr_b && (addr_a == addr_b)) e_coll[k] = 1'b1;
               if (en_b && wr_b && int'(addr_b) < depth_m[k] &&
                   !(en_a && wr_a && addr_a == addr_b))
                  mm[k][addr_b] = din_b;
               if (en_a && wr_a && int'(addr_a) < depth_m[k])
                  mm[k][addr_a] = din_a;
            end
            e_busy[k] = (busy_left[k] > 0);
            if (orm_m[k] == 0) begin
               e_va[k] = va; if (va) e_da[k] = ra;
               e_vb[k] = vb; if (vb) e_db[k] = rb;
            end else begin
               e_va[k] = p_va[k]; if (p_va[k]) e_da[k] = p_da[k];
               e_vb[k] = p_vb[k]; if (p_vb[k]) e_db[k] = p_db[k];
               p_va[k] = va; if (va) p_da[k] = ra;
               p_vb[k] = vb; if (vb) p_db[k] = rb;
            end
         end
      end
   endtask

   task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      cmp("d0.dout_a", 32'(dout_a0), 32'(e_da[0]));
      cmp("d0.valid_a", 32'(valid_a0), 32'(e_va[0]));
      cmp("d0.dout_b", 32'(dout_b0), 32'(e_db[0]));
      cmp("d0.valid_b", 32'(valid_b0), 32'(e_vb[0]));
      cmp("d0.busy", 32'(busy0), 32'(e_busy[0]));
      cmp("d0.collision", 32'(coll0), 32'(e_coll[0]));
      cmp("d1.dout_a", 32'(dout_a1), 32'(e_da[1]));
      cmp("d1.valid_a", 32'(valid_a1), 32'(e_va[1]));
      cmp("d1.dout_b", 32'(dout_b1), 32'(e_db[1]));
      cmp("d1.valid_b", 32'(valid_b1), 32'(e_vb[1]));
      cmp("d1.busy", 32'(busy1), 32'(e_busy[1]));
      cmp("d1.collision", 32'(coll1), 32'(e_coll[1]));
   endtask

   // ---------------- driver tasks ----------------
   // Inputs are driven at the falling edge; outputs are checked at the next one.
   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic set_idle();
      en_a = 1'b0; wr_a = 1'b0; addr_a = '0; din_a = '0;
      en_b = 1'b0; wr_b = 1'b0; addr_b = '0; din_b = '0;
   endtask

   task automatic acc(input logic ea, input logic wa, input int aa, input int da,
                      input logic eb, input logic wb, input int ab, input int db);
      en_a = ea; wr_a = wa; addr_a = AW'(aa); din_a = DW'(da);
      en_b = eb; wr_b = wb; addr_b = AW'(ab); din_b = DW'(db);
   endtask

   task automatic rand_inputs(input int focus);
      en_a   = ($urandom_range(0, 3) != 0);
      wr_a   = $urandom_range(0, 1) != 0;
      en_b   = ($urandom_range(0, 3) != 0);
      wr_b   = $urandom_range(0, 1) != 0;
      addr_a = (focus != 0 && $urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7))
                                                         : AW'($urandom_range(0, 63));
      addr_b = (focus != 0 && $urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7))
                                                         : AW'($urandom_range(0, 63));
      din_a  = DW'($urandom);
      din_b  = DW'($urandom);
   endtask

   // Pulse reset for one edge, then count cycles with busy high per instance.
   // Random accesses are issued while both instances are still clearing.
   task automatic reset_and_count(input int stim);
      int c0, c1, guard;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      c0 = 0; c1 = 0; guard = 0;
      while ((busy0 || busy1) && guard < 200) begin
         if (busy0) c0++;
         if (busy1) c1++;
         if (stim != 0 && busy1) rand_inputs(1); else set_idle();
         tick();
         guard++;
      end
      set_idle();
      cmp("busy_timeout", 32'(busy0 | busy1), 32'd0);
      cmp("busy_len_d0", 32'(c0), 32'd64);
      cmp("busy_len_d1", 32'(c1), 32'd48);
   endtask

   task automatic read_all_zero();
      for (int a = 0; a < 64; a++) begin
         acc(1, 0, a, 0, 1, 0, 63 - a, 0);
         tick();
         cmp("clr_rd_a", 32'(dout_a0), 32'h0);
         cmp("clr_rd_b", 32'(dout_b0), 32'h0);
      end
      set_idle();
      tick();
   endtask

   // ---------------- scenario ----------------
   initial begin
      set_idle();
      rst = 1'b1;
      @(negedge clk);

      // Reset state and clear length, then the whole array reads zero.
      reset_and_count(0);
      read_all_zero();

      // Cross reads of freshly written words.
      acc(1, 1, 0, 8'h01, 1, 1, 1, 8'h12); tick();
      acc(1, 0, 1, 0, 1, 0, 0, 0); tick();
      cmp("xrd_a_d0", 32'(dout_a0), 32'h12);
      cmp("xrd_b_d0", 32'(dout_b0), 32'h01);
      cmp("xrd_va_d0", 32'(valid_a0), 32'h1);
      set_idle(); tick();
      cmp("xrd_a_d1", 32'(dout_a1), 32'h12);
      cmp("xrd_b_d1", 32'(dout_b1), 32'h01);
      cmp("xrd_va0_idle", 32'(valid_a0), 32'h0);

      // Write-write collision at address 2: A wins.
      acc(1, 1, 2, 8'h03, 1, 1, 2, 8'h13); tick();
      cmp("coll_d0", 32'(coll0), 32'h1);
      cmp("coll_d1", 32'(coll1), 32'h1);
      set_idle(); tick();
      cmp("coll_end_d0", 32'(coll0), 32'h0);
      acc(1, 0, 2, 0, 0, 0, 0, 0); tick();
      cmp("coll_rd_d0", 32'(dout_a0), 32'h03);

      // Read-during-write at address 4, same port and cross port.
      acc(1, 1, 4, 8'h05, 0, 0, 0, 0); tick();
      acc(1, 1, 4, 8'h15, 1, 0, 4, 0); tick();
      cmp("rdw_a_d0", 32'(dout_a0), 32'h05);
      cmp("rdw_b_d0", 32'(dout_b0), 32'h05);
      set_idle(); tick();
      cmp("rdw_a_d1", 32'(dout_a1), 32'h15);
      cmp("rdw_b_d1", 32'(dout_b1), 32'h05);

      // Output register latency and hold on idle cycles.
      acc(1, 1, 3, 8'h04, 0, 0, 0, 0); tick();
      set_idle(); tick(); tick();
      acc(1, 0, 3, 0, 0, 0, 0, 0); tick();
      cmp("lat_v1_early", 32'(valid_a1), 32'h0);
      set_idle(); tick();
      cmp("lat_v1", 32'(valid_a1), 32'h1);
      cmp("lat_d1", 32'(dout_a1), 32'h04);
      tick();
      cmp("hold_v1", 32'(valid_a1), 32'h0);
      cmp("hold_d1", 32'(dout_a1), 32'h04);

      // Out-of-range only for the 48-word instance.
      acc(1, 1, 50, 8'h77, 0, 0, 0, 0); tick();
      acc(1, 0, 50, 0, 0, 0, 0, 0); tick();
      cmp("oor_d0", 32'(dout_a0), 32'h77);
      set_idle(); tick();
      cmp("oor_d1", 32'(dout_a1), 32'h00);
      cmp("oor_v1", 32'(valid_a1), 32'h1);

      // Reset in the middle of a clear, with accesses issued while busy.
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 30; i++) begin rand_inputs(1); tick(); end
      set_idle();
      reset_and_count(1);
      read_all_zero();

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         rand_inputs(1);
         rst = ($urandom_range(0, 999) == 0);
         tick();
      end
      rst = 1'b0;
      set_idle();
      for (int i = 0; i < 80; i++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
